counter_run_ctrl: RTL and testbench
===================================

Name: counter_run_ctrl

Overview:
- Run controller for a pipelined up-count datapath. On a start pulse it issues one count word per cycle, from 0 up to a programmed limit.
- Words travel through a STAGES-deep valid-tagged pipeline before reaching the output register.
- The controller tracks in-flight words, drains the pipeline on completion or abort, and signals done.
- Sits between a software/sequencer start interface and downstream consumers of the count stream.

Parameters:
- N, 4, count width in bits; also the width of limit and q.
- STAGES, 2, number of pipeline stages between issue and the output register (STAGES >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request, sampled in IDLE only.
- limit  input  N  last value to issue, captured when start is accepted.
- abort  input  1  stop issuing, sampled in RUN only.
- busy  output  1  high in every state except IDLE.
- q  output  N  count word at the pipeline output.
- q_valid  output  1  q carries a valid word this cycle.
- done  output  1  one-cycle pulse when a run has fully drained.
- aborted  output  1  run ended by abort; valid while done is high, held until the next accepted start.

Behaviour:
- Reset (async, active-high): state=IDLE; cnt=0; lim_r=0; all stage values/valids=0; q=0; q_valid=0; done=0; busy=0; aborted=0.
- FSM states: IDLE, RUN, DRAIN, DONE. State is registered; busy and done are decoded from state (busy = state!=IDLE, done = state==DONE).
- IDLE:
  - start=1 -> lim_r<=limit, cnt<=0, aborted<=0, go to RUN.
  - Simultaneous start+abort in IDLE: start accepted, abort ignored.
- RUN, each cycle with abort=0:
  - Issue: stage0<=cnt with valid=1; cnt<=cnt+1 (mod 2^N).
  - If cnt==lim_r on this issue -> go to DRAIN.
- RUN with abort=1: no issue that edge (stage0 valid<=0), aborted<=1, go to DRAIN. Abort on the same cycle as the final issue wins; that word is not issued.
- Pipeline:
  - stage[i]<=stage[i-1] (value and valid) every cycle, in all states.
  - Last stage -> output register: q_valid<=stage[STAGES-1].valid.
  - q<=stage[STAGES-1].value only when that valid is set; otherwise q holds its previous value.
  - Issue-to-output latency = STAGES cycles: a word issued at edge k appears on q with q_valid=1 in the cycle after edge k+STAGES.
- DRAIN: no issue. When all stage valid bits are 0 -> go to DONE. This cycle may coincide with the last q_valid.
- DONE: done=1 for exactly one cycle, then IDLE. aborted holds.
- Run with no abort:
  - Issues limit+1 words 0..limit on consecutive cycles; q_valid is contiguous for limit+1 cycles.
  - Start accepted at edge s -> first q_valid in cycle after edge s+1+STAGES.
  - done in cycle after edge s+limit+STAGES+2, i.e. the cycle immediately after the last q_valid.
- Boundaries:
  - limit=0: exactly one word (0).
  - limit=2^N-1: all 2^N values issued; cnt wraps to 0 internally but the wrapped value is never issued.
  - Abort on the first RUN cycle: zero words issued; DRAIN exits after one cycle; done pulses with aborted=1.
  - start while busy is ignored and does not re-latch limit. abort outside RUN is ignored.
  - reset mid-run clears all in-flight words immediately; no done is emitted.

Test Plan:
- N=4, STAGES=2; start with limit=3 at edge s -> q_valid in cycles s+3..s+6 with q=0,1,2,3; done=1 only in cycle s+7; aborted=0; busy=0 from s+8.
- limit=0 -> single q_valid cycle with q=0; done in the following cycle.
- limit=15 -> 16 contiguous words 0..15; no word 0 after 15; done the cycle after q=15.
- limit=9, abort asserted in the RUN cycle where cnt=4 -> q outputs 0,1,2,3 only; done pulses with aborted=1; q holds 3 afterwards.
- start pulsed again during RUN and DONE with a different limit -> ignored; original sequence and limit unchanged.
- reset asserted asynchronously mid-RUN with words in flight -> all outputs 0 immediately; after release a new start (limit=2) runs cleanly 0,1,2 with done.

Source files
------------

// File: rtl/counter_run_ctrl.sv
// Run controller for a pipelined up-count datapath: issues 0..limit one word per
// cycle through a valid-tagged pipeline, drains it on completion or abort, then pulses done.
module counter_run_ctrl #(
    parameter int N      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] limit,
    input  logic         abort,
    output logic         busy,
    output logic [N-1:0] q,
    output logic         q_valid,
    output logic         done,
    output logic         aborted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        cnt_q, cnt_d;
    logic [N-1:0]        lim_q, lim_d;
    logic                aborted_q, aborted_d;
    logic                issue_s;
    logic [N-1:0]        stage_val_q [STAGES];
    logic [STAGES-1:0]   stage_vld_q;
    logic [N-1:0]        q_q;
    logic                q_valid_q;

    // Next-state and issue decision; abort in RUN suppresses the issue on that edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lim_d     = lim_q;
        aborted_d = aborted_q;
        issue_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lim_d     = limit;
                    cnt_d     = {N{1'b0}};
                    aborted_d = 1'b0;
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    issue_s = 1'b1;
                    cnt_d   = cnt_q + N'(1);
                    if (cnt_q == lim_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (stage_vld_q == {STAGES{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers: FSM state, issue counter, latched limit, abort flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {N{1'b0}};
            lim_q     <= {N{1'b0}};
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lim_q     <= lim_d;
            aborted_q <= aborted_d;
        end
    end

    // Valid-tagged pipeline; shifts every cycle regardless of FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_val_q[i] <= {N{1'b0}};
            end
            stage_vld_q <= {STAGES{1'b0}};
        end else begin
            stage_val_q[0] <= cnt_q;
            stage_vld_q[0] <= issue_s;
            for (int i = 1; i < STAGES; i++) begin
                stage_val_q[i] <= stage_val_q[i-1];
                stage_vld_q[i] <= stage_vld_q[i-1];
            end
        end
    end

    // Output register; q keeps the last valid word when the pipeline is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q       <= {N{1'b0}};
            q_valid_q <= 1'b0;
        end else begin
            q_valid_q <= stage_vld_q[STAGES-1];
            if (stage_vld_q[STAGES-1]) begin
                q_q <= stage_val_q[STAGES-1];
            end else begin
                q_q <= q_q;
            end
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Scoreboard bench for counter_run_ctrl: a run-level model pushes expected words and
// done events with their cycle numbers; a negedge monitor pops and compares.
module tb_counter_run_ctrl;
    localparam int N      = 4;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] limit;
    logic         abort;
    logic         busy;
    logic [N-1:0] q;
    logic         q_valid;
    logic         done;
    logic         aborted;

    counter_run_ctrl #(.N(N), .STAGES(STAGES)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .limit   (limit),
        .abort   (abort),
        .busy    (busy),
        .q       (q),
        .q_valid (q_valid),
        .done    (done),
        .aborted (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t word_q[$];
    exp_t done_q[$];
    int   edge_cnt   = 0;
    int   vectors    = 0;
    int   miscompares = 0;
    int   last_word  = 0;
    bit   last_ab    = 1'b0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, edge_cnt);
        end
    endtask

    // Monitor: every presented word / done pulse must match the head of its queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (q_valid === 1'b1) begin
                if (word_q.size() == 0) begin
                    check("unexpected_q_valid", 1, 0);
                end else begin
                    e = word_q.pop_front();
                    check("q_value", int'(q), e.val);
                    check("q_cycle", edge_cnt, e.cyc);
                end
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = done_q.pop_front();
                    check("done_aborted", int'(aborted), e.val);
                    check("done_cycle", edge_cnt, e.cyc);
                end
            end
        end
    end

    // Reference model of one run: words 0..L unless an abort lands while still issuing.
    task automatic launch(input int lim, input int a);
        int  s;
        int  w;
        bit  ab;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        limit = lim[N-1:0];
        s  = edge_cnt + 1;
        ab = (a >= 0) && (a <= lim);
        w  = ab ? a : lim + 1;
        for (int j = 0; j < w; j++) begin
            e.val = j;
            e.cyc = s + 1 + STAGES + j;
            word_q.push_back(e);
        end
        e.val = ab ? 1 : 0;
        e.cyc = (w > 0) ? s + w + STAGES + 1 : s + 2;
        done_q.push_back(e);
        if (w > 0) last_word = w - 1;
        last_ab = ab;
        @(negedge clk);
        start = 1'b0;
        limit = N'($urandom);
    endtask

    task automatic run(input int lim, input int a, input bit poke);
        int t;
        int last_c;
        launch(lim, a);
        last_c = (a > 1) ? a : 1;
        for (int c = 0; c <= last_c; c++) begin
            if (c == a) abort = 1'b1;
            if (poke && c == 1) begin
                start = 1'b1;
                limit = ~lim[N-1:0];
            end
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
        end
        t = 0;
        while ((word_q.size() != 0 || done_q.size() != 0) && t < 200) begin
            @(negedge clk);
            #1;
            start = 1'b0;
            if (poke && done === 1'b1) begin
                start = 1'b1;
                limit = ~lim[N-1:0];
            end
            t++;
        end
        if (t >= 200) begin
            check("run_timeout", t, 0);
            word_q.delete();
            done_q.delete();
        end
        @(negedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_run", int'(busy), 0);
        check("q_hold", int'(q), last_word);
        check("aborted_hold", int'(aborted), last_ab ? 1 : 0);
    endtask

    initial begin
        int lim;
        int a;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        limit = '0;
        repeat (2) @(negedge clk);
        check("rst_q", int'(q), 0);
        check("rst_q_valid", int'(q_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_aborted", int'(aborted), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run(3, -1, 1'b0);
        run(0, -1, 1'b0);
        run(15, -1, 1'b0);
        run(9, 4, 1'b0);
        run(5, 0, 1'b0);
        run(7, -1, 1'b1);
        run(6, 6, 1'b1);

        // Reset mid-run with words in flight: everything clears, no done follows.
        launch(10, -1);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_q", int'(q), 0);
        check("mid_rst_q_valid", int'(q_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_aborted", int'(aborted), 0);
        word_q.delete();
        done_q.delete();
        last_word = 0;
        last_ab   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'(busy), 0);
        run(2, -1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            lim = int'($urandom_range(0, 15));
            a   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, lim + 1)) : -1;
            run(lim, a, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
